// File: rtl/ser_reg_pkg.sv
`default_nettype none
// ============================================================
// ser_reg_pkg : shared FSM encoding and counter sizing
// Rev 1.0
// ============================================================
package ser_reg_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_DATA   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // Sized so it can hold the longer of the two phase lengths minus one.
  function automatic int ctr_width(input int aw, input int dw);
    return $clog2((aw > dw) ? aw : dw) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_reg_ctrl.sv
`default_nettype none
// ============================================================
// ser_reg_ctrl : transaction FSM, phase counter, BUSY, strobes
// Rev 1.0
// ============================================================
module ser_reg_ctrl
  import ser_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic   CLK,
  input  logic   RSTN,
  input  logic   i_rd_en,
  input  logic   i_wr_en,
  output state_t o_state,
  output logic   o_busy,
  output logic   o_op_wr,
  output logic   o_last,
  output logic   o_dual
);

  localparam int c_ctr_w = ctr_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [c_ctr_w-1:0] c_addr_ld = c_ctr_w'(ADDR_WIDTH - 1);
  localparam logic [c_ctr_w-1:0] c_data_ld = c_ctr_w'(DATA_WIDTH - 1);

  state_t             r_state;
  logic [c_ctr_w-1:0] r_ctr;
  logic               r_busy;
  logic               r_op_wr;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_ctr   <= '0;
      r_busy  <= 1'b0;
      r_op_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Both strobes together is an error, not a transaction.
          if (i_rd_en ^ i_wr_en) begin
            r_state <= S_ADDR;
            r_ctr   <= c_addr_ld;
            r_busy  <= 1'b1;
            r_op_wr <= i_wr_en;
          end
        end
        S_ADDR: begin
          if (r_ctr == '0) begin
            r_state <= S_DATA;
            r_ctr   <= c_data_ld;
          end else begin
            r_ctr <= r_ctr - 1'b1;
          end
        end
        S_DATA: begin
          if (r_ctr == '0) begin
            if (r_op_wr) begin
              r_state <= S_COMMIT;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ctr <= r_ctr - 1'b1;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_busy  = r_busy;
  assign o_op_wr = r_op_wr;
  assign o_last  = (r_ctr == '0);
  assign o_dual  = (r_state == S_IDLE) && i_rd_en && i_wr_en;

endmodule
`default_nettype wire

// File: rtl/ser_reg_file.sv
`default_nettype none
// ============================================================
// ser_reg_file : serially accessed register file (top)
// Rev 1.0
// ============================================================
module ser_reg_file
  import ser_reg_pkg::*;
#(
  parameter int                          N_REG      = 5,
  parameter int                          ADDR_WIDTH = 8,
  parameter int                          DATA_WIDTH = 8,
  parameter logic [N_REG*ADDR_WIDTH-1:0] ADDR       = 40'h5506A17834,
  parameter logic [N_REG*DATA_WIDTH-1:0] INIT       = 40'h3300000000,
  parameter logic [N_REG-1:0]            RO_MASK    = 5'b10000
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic RD_EN,
  input  logic WR_EN,
  input  logic DIN,
  output logic DOUT,
  output logic BUSY,
  output logic ERR
);

  state_t w_state;
  logic   w_busy;
  logic   w_op_wr;
  logic   w_last;
  logic   w_dual;

  ser_reg_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ctrl (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_rd_en (RD_EN),
    .i_wr_en (WR_EN),
    .o_state (w_state),
    .o_busy  (w_busy),
    .o_op_wr (w_op_wr),
    .o_last  (w_last),
    .o_dual  (w_dual)
  );

  logic w_addr_ph, w_addr_last, w_data_ph, w_data_last, w_commit;
  assign w_addr_ph   = (w_state == S_ADDR);
  assign w_addr_last = w_addr_ph && w_last;
  assign w_data_ph   = (w_state == S_DATA);
  assign w_data_last = w_data_ph && w_last;
  assign w_commit    = (w_state == S_COMMIT);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_snap;
  logic [N_REG-1:0]      r_sel;
  logic                  r_match;
  logic                  r_dout;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_regs [N_REG];

  // Decode uses the address including the bit arriving this cycle, so the
  // snapshot and first DOUT bit are ready on the ADDR->DATA edge.
  assign w_addr_nxt = (r_addr << 1) | ADDR_WIDTH'(DIN);

  logic [N_REG-1:0] w_hit;
  for (genvar i = 0; i < N_REG; i++) begin : g_dec
    assign w_hit[i] = (w_addr_nxt == ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  logic [DATA_WIDTH-1:0] w_rd_val;
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (w_hit[i]) w_rd_val = w_rd_val | r_regs[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_addr   <= '0;
      r_shadow <= '0;
      r_snap   <= '0;
      r_sel    <= '0;
      r_match  <= 1'b0;
      r_dout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_dual ||
               (w_data_last && (!r_match || (w_op_wr && |(r_sel & RO_MASK))));

      if (w_addr_ph) r_addr <= w_addr_nxt;

      if (w_addr_last) begin
        r_sel   <= w_hit;
        r_match <= |w_hit;
        r_dout  <= !w_op_wr && w_rd_val[DATA_WIDTH-1];
        r_snap  <= w_rd_val << 1;
      end else if (w_data_ph && !w_op_wr && !w_last) begin
        r_dout <= r_snap[DATA_WIDTH-1];
        r_snap <= r_snap << 1;
      end else begin
        r_dout <= 1'b0;
      end

      if (w_data_ph) r_shadow <= (r_shadow << 1) | DATA_WIDTH'(DIN);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < N_REG; i++) r_regs[i] <= INIT[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (w_commit) begin
      for (int i = 0; i < N_REG; i++) begin
        if (r_sel[i] && !RO_MASK[i]) r_regs[i] <= r_shadow;
      end
    end
  end

  assign DOUT = r_dout;
  assign BUSY = w_busy;
  assign ERR  = r_err;

endmodule
`default_nettype wire

// File: doc/ser_reg_file.md
SER_REG_FILE -- requirements
Module: ser_reg_file

Interface
REQ-001 SHALL have parameter N_REG, default 5, number of registers (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, serial address length in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, register width in bits.
REQ-004 SHALL have parameter ADDR [N_REG*ADDR_WIDTH-1:0], default 40'h5506A17834, register i address in slice i (unique values).
REQ-005 SHALL have parameter INIT [N_REG*DATA_WIDTH-1:0], default 40'h3300000000, reset value of register i in slice i.
REQ-006 SHALL have parameter RO_MASK [N_REG-1:0], default 5'b10000; a set bit marks register i read-only.
REQ-007 CLK  input  1  sole clock; all logic on rising edge.
REQ-008 RSTN  input  1  reset, synchronous, active-low.
REQ-009 RD_EN  input  1  read start strobe.
REQ-010 WR_EN  input  1  write start strobe.
REQ-011 DIN  input  1  serial address/write data, MSB first.
REQ-012 DOUT  output  1  serial read data, MSB first, registered.
REQ-013 BUSY  output  1  high while a transaction is in progress.
REQ-014 ERR  output  1  one-cycle error pulse, registered.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, COMMIT.
REQ-016 In IDLE, exactly one of RD_EN/WR_EN high SHALL latch the operation type and move to ADDR next cycle; BUSY high from that next cycle.
REQ-017 RD_EN and WR_EN high together in IDLE SHALL be ignored (stay IDLE) and pulse ERR next cycle.
REQ-018 RD_EN/WR_EN while BUSY SHALL be ignored; a transaction is never restarted.
REQ-019 ADDR SHALL last ADDR_WIDTH cycles, shifting DIN MSB first into the address register, then go to DATA.
REQ-020 DATA SHALL last DATA_WIDTH cycles, counted by a down-counter of width clog2(max(ADDR_WIDTH,DATA_WIDTH))+1.
REQ-021 Read: DOUT SHALL carry bit DATA_WIDTH-1-k of the addressed register in DATA cycle k (k=0 first), read from a snapshot taken on ADDR->DATA; the register itself is not shifted or modified.
REQ-022 DOUT SHALL be 0 in all cycles other than read DATA cycles, and for reads of unmatched addresses.
REQ-023 Write: DIN in DATA cycles SHALL shift into a shadow register; in COMMIT (one cycle) the shadow SHALL be written atomically to the matched register, then return to IDLE.
REQ-024 Read SHALL return to IDLE directly after the last DATA cycle; BUSY low in the cycle IDLE is re-entered.
REQ-025 Unmatched address SHALL complete full transaction timing and pulse ERR in the cycle after the last DATA cycle, with no register change.
REQ-026 Write to a RO_MASK register SHALL change nothing and pulse ERR in the COMMIT cycle.
REQ-027 A read after a write to the same address SHALL return the newly committed value; back-to-back transactions SHALL be accepted from the first IDLE cycle.

Reset
REQ-028 RSTN low at a clock edge SHALL set state IDLE, counter 0, address/shadow/snapshot 0, register i to INIT slice i, DOUT 0, BUSY 0, ERR 0.
REQ-029 Reset mid-transaction SHALL abort it; a partially shifted write SHALL NOT reach any register.

Structure
REQ-030 FSM state encodings and the counter-width function SHALL reside in shared package ser_reg_pkg.
REQ-031 FSM, counter, BUSY and strobe arbitration SHALL be sub-module ser_reg_ctrl; register array, address decode and DOUT mux in the top.

Verification
REQ-032 Reset, read 0x55 (reg 4) -> DOUT 0,0,1,1,0,0,1,1 in DATA cycles, ERR 0, reg unchanged.
REQ-033 Write 0xA5 to 0x78, then read 0x78 -> DOUT 1,0,1,0,0,1,0,1; second read same value (non-destructive).
REQ-034 Write 0xFF to 0x55 -> ERR pulse in COMMIT cycle; following read returns 0x33.
REQ-035 Read 0x00 (unmatched) -> DOUT all 0, ERR pulse after last DATA cycle; RD_EN+WR_EN together in IDLE -> ERR pulse, BUSY stays 0.
REQ-036 Write 0x3C to 0x34, RSTN low after 4 data bits -> after reset reads of 0x34 return 0x00, BUSY 0; WR_EN during ADDR of a read -> ignored, read completes normally.
